// File: rtl/multicycle_seq_rv32i_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer: state encodings,
// major opcodes and trap cause codes.
package rv32i_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'b000,
        ST_DECODE = 3'b001,
        ST_EXEC   = 3'b010,
        ST_MEM    = 3'b011,
        ST_WB     = 3'b100,
        ST_HALT   = 3'b101,
        ST_TRAP   = 3'b110
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_ILLEGAL  = 2'b01,
        CAUSE_FETCH_TO = 2'b10,
        CAUSE_DATA_TO  = 2'b11
    } cause_t;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    // True for opcodes that proceed through EXEC (SYSTEM is handled separately).
    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: is_legal = 1'b1;
            default:                           is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_seq_rv32i_if.sv
// Shared single-port memory handshake between the sequencer and memory.
interface multicycle_seq_rv32i_if;
    logic mem_req;
    logic mem_we;
    logic mem_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_sel, output mem_ready);
endinterface

// File: rtl/multicycle_seq_rv32i_mem_wdog.sv
// Memory wait watchdog: counts stalled request cycles and flags the last
// allowed cycle so the sequencer can trap if ready still has not arrived.
module mem_wdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic nreset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT);

    logic [W-1:0] cnt_reg;

    // Wait counter; clear has priority so every state entry starts from zero.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (count_en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign expired = (cnt_reg == W'(TIMEOUT - 1));
endmodule

// File: rtl/multicycle_seq_rv32i.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB stepping over a
// shared memory port, with gated write strobes, HALT and sticky TRAP.
module multicycle_seq_rv32i
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic [6:0]              opcode,
    input  logic                    cu_rdwrite,
    input  logic                    cu_store,
    input  logic                    resume,
    multicycle_seq_rv32i_if.master  mem,
    output logic                    ir_we,
    output logic                    pc_we,
    output logic                    rf_we,
    output logic                    halted,
    output logic                    trap,
    output logic [1:0]              trap_cause,
    output logic [CNT_W-1:0]        instret,
    output logic [2:0]              state_o
);
    state_t           state_reg, state_next;
    cause_t           cause_reg, cause_next;
    logic [CNT_W-1:0] instret_reg;
    logic             wd_clear, wd_count_en, wd_expired;
    logic             req_next, we_next, sel_next;

    mem_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clock    (clock),
        .nreset   (nreset),
        .clear    (wd_clear),
        .count_en (wd_count_en),
        .expired  (wd_expired)
    );

    // State, trap cause and retired-instruction counter registers.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_reg   <= ST_FETCH;
            cause_reg   <= CAUSE_NONE;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
            if (state_reg == ST_WB) begin
                instret_reg <= instret_reg + 1'b1;
            end
        end
    end

    // Next-state and strobe decode; ready beats a same-cycle timeout.
    always_comb begin
        state_next  = state_reg;
        cause_next  = cause_reg;
        req_next    = 1'b0;
        we_next     = 1'b0;
        sel_next    = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        rf_we       = 1'b0;
        halted      = 1'b0;
        trap        = 1'b0;
        wd_count_en = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                req_next    = 1'b1;
                ir_we       = mem.mem_ready & nreset;
                wd_count_en = ~mem.mem_ready;
                if (mem.mem_ready) begin
                    state_next = ST_DECODE;
                end else if (wd_expired) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_FETCH_TO;
                end
            end
            ST_DECODE: begin
                if (opcode == OP_SYSTEM) begin
                    state_next = ST_HALT;
                end else if (is_legal(opcode)) begin
                    state_next = ST_EXEC;
                end else begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC: begin
                state_next = (opcode == OP_LOAD || opcode == OP_STORE) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                req_next    = 1'b1;
                sel_next    = 1'b1;
                we_next     = cu_store;
                wd_count_en = ~mem.mem_ready;
                if (mem.mem_ready) begin
                    state_next = ST_WB;
                end else if (wd_expired) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_DATA_TO;
                end
            end
            ST_WB: begin
                rf_we      = cu_rdwrite;
                pc_we      = 1'b1;
                state_next = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
                if (resume) begin
                    state_next = ST_WB;
                end
            end
            ST_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
        wd_clear = (state_next != state_reg);
    end

    assign mem.mem_req = req_next;
    assign mem.mem_we  = we_next;
    assign mem.mem_sel = sel_next;
    assign trap_cause  = cause_reg;
    assign instret     = instret_reg;
    assign state_o     = state_reg;
endmodule

// File: tb/tb_multicycle_seq_rv32i.sv
// Directed bench for multicycle_seq_rv32i: a table of instructions stepped
// cycle by cycle against an expected state trace, plus hand-written HALT,
// timeout, illegal-opcode and reset sequences.
module tb_multicycle_seq_rv32i;

    localparam logic [2:0] S_FETCH  = 3'b000;
    localparam logic [2:0] S_DECODE = 3'b001;
    localparam logic [2:0] S_EXEC   = 3'b010;
    localparam logic [2:0] S_MEM    = 3'b011;
    localparam logic [2:0] S_WB     = 3'b100;
    localparam logic [2:0] S_HALT   = 3'b101;
    localparam logic [2:0] S_TRAP   = 3'b110;

    logic        clock;
    logic        nreset;
    logic [6:0]  opcode;
    logic        cu_rdwrite;
    logic        cu_store;
    logic        resume;
    logic        ir_we, pc_we, rf_we, halted, trap;
    logic [1:0]  trap_cause;
    logic [31:0] instret;
    logic [2:0]  state_o;

    multicycle_seq_rv32i_if bus ();

    multicycle_seq_rv32i #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clock      (clock),
        .nreset     (nreset),
        .opcode     (opcode),
        .cu_rdwrite (cu_rdwrite),
        .cu_store   (cu_store),
        .resume     (resume),
        .mem        (bus),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .rf_we      (rf_we),
        .halted     (halted),
        .trap       (trap),
        .trap_cause (trap_cause),
        .instret    (instret),
        .state_o    (state_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_instret = 0;
    logic [1:0]  exp_cause   = 2'b00;

    typedef struct {
        logic [6:0] op;
        logic       rdw;
        logic       st;
        int         fw;     // fetch wait cycles before ready
        int         mw;     // MEM wait cycles before ready
        logic       noise;  // mem_ready driven high in non-memory cycles
        int         cycles; // hand-computed instruction length
    } vec_t;

    vec_t vecs[12];

    // Expected {mem_req, mem_sel, mem_we, ir_we, pc_we, rf_we, halted, trap}.
    function automatic logic [7:0] exp_strobes(input logic [2:0] s, input logic rdy,
                                               input logic rdw, input logic st);
        logic [7:0] r;
        r = 8'h00;
        case (s)
            S_FETCH: r = {1'b1, 1'b0, 1'b0, rdy, 4'b0000};
            S_MEM:   r = {1'b1, 1'b1, st, 5'b00000};
            S_WB:    r = {4'b0000, 1'b1, rdw, 2'b00};
            S_HALT:  r = 8'b0000_0010;
            S_TRAP:  r = 8'b0000_0001;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [44:0] observed();
        return {state_o, bus.mem_req, bus.mem_sel, bus.mem_we, ir_we, pc_we, rf_we,
                halted, trap, trap_cause, instret};
    endfunction

    task automatic compare(input string name, input logic [44:0] exp_v);
        logic [44:0] got;
        got = observed();
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL %s: got state=%0d strobes=%b cause=%b instret=%0d, want state=%0d strobes=%b cause=%b instret=%0d",
                     name, got[44:42], got[41:34], got[33:32], got[31:0],
                     exp_v[44:42], exp_v[41:34], exp_v[33:32], exp_v[31:0]);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check outputs just after.
    task automatic cyc(input string name, input logic [2:0] s, input logic rdy,
                       input logic [6:0] op, input logic rdw, input logic st, input logic res);
        @(negedge clock);
        bus.mem_ready = rdy;
        opcode        = op;
        cu_rdwrite    = rdw;
        cu_store      = st;
        resume        = res;
        #1;
        compare(name, {s, exp_strobes(s, rdy, rdw, st), exp_cause, exp_instret});
    endtask

    // Reset with mem_ready high: strobes must still be in their reset values.
    task automatic do_reset(input string name);
        @(negedge clock);
        nreset        = 1'b0;
        bus.mem_ready = 1'b1;
        cu_rdwrite    = 1'b1;
        cu_store      = 1'b1;
        #1;
        exp_cause   = 2'b00;
        exp_instret = 0;
        compare(name, {S_FETCH, 8'b1000_0000, 2'b00, 32'd0});
        bus.mem_ready = 1'b0;
        @(posedge clock);
        #1 nreset = 1'b1;
    endtask

    task automatic run_instr(input vec_t v);
        int n;
        n = 0;
        for (int i = 0; i <= v.fw; i++) begin
            cyc("fetch", S_FETCH, (i == v.fw), 7'h00, v.rdw, v.st, 1'b0);
            n++;
        end
        cyc("decode", S_DECODE, v.noise, v.op, v.rdw, v.st, 1'b0);
        cyc("exec", S_EXEC, v.noise, v.op, v.rdw, v.st, 1'b0);
        n += 2;
        if (v.op == 7'h03 || v.op == 7'h23) begin
            for (int i = 0; i <= v.mw; i++) begin
                cyc("mem", S_MEM, (i == v.mw), v.op, v.rdw, v.st, 1'b0);
                n++;
            end
        end
        cyc("wb", S_WB, v.noise, v.op, v.rdw, v.st, 1'b0);
        n++;
        exp_instret++;
        $display("instr op=%h rdw=%0d st=%0d fw=%0d mw=%0d cycles=%0d (table %0d)",
                 v.op, v.rdw, v.st, v.fw, v.mw, n, v.cycles);
    endtask

    initial begin
        nreset        = 1'b0;
        opcode        = 7'h00;
        cu_rdwrite    = 1'b0;
        cu_store      = 1'b0;
        resume        = 1'b0;
        bus.mem_ready = 1'b0;

        vecs[0]  = '{7'h33, 1'b1, 1'b0, 0,  0,  1'b0, 4};
        vecs[1]  = '{7'h13, 1'b1, 1'b0, 0,  0,  1'b0, 4};
        vecs[2]  = '{7'h37, 1'b1, 1'b0, 0,  0,  1'b1, 4};
        vecs[3]  = '{7'h03, 1'b1, 1'b0, 0,  3,  1'b0, 8};
        vecs[4]  = '{7'h23, 1'b0, 1'b1, 0,  0,  1'b1, 5};
        vecs[5]  = '{7'h63, 1'b0, 1'b0, 2,  0,  1'b0, 6};
        vecs[6]  = '{7'h6F, 1'b1, 1'b0, 0,  0,  1'b0, 4};
        vecs[7]  = '{7'h67, 1'b1, 1'b0, 1,  0,  1'b1, 5};
        vecs[8]  = '{7'h17, 1'b1, 1'b0, 0,  0,  1'b0, 4};
        vecs[9]  = '{7'h23, 1'b1, 1'b1, 0,  2,  1'b0, 7};
        vecs[10] = '{7'h33, 1'b1, 1'b0, 15, 0,  1'b0, 19};
        vecs[11] = '{7'h03, 1'b1, 1'b0, 0,  15, 1'b1, 20};

        do_reset("reset_initial");

        for (int k = 0; k < 12; k++) begin
            run_instr(vecs[k]);
        end

        // ECALL: halt without retiring, then resume retires it through WB.
        cyc("ecall_fetch", S_FETCH, 1'b1, 7'h00, 1'b0, 1'b0, 1'b0);
        cyc("ecall_decode", S_DECODE, 1'b0, 7'h73, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc("halt", S_HALT, i[0], 7'h73, 1'b1, 1'b1, 1'b0);
        end
        cyc("halt_resume", S_HALT, 1'b0, 7'h73, 1'b0, 1'b0, 1'b1);
        cyc("ecall_wb", S_WB, 1'b0, 7'h73, 1'b0, 1'b0, 1'b0);
        exp_instret++;
        cyc("ecall_next_fetch", S_FETCH, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        cyc("ecall_next_fetch2", S_FETCH, 1'b1, 7'h00, 1'b0, 1'b0, 1'b0);
        cyc("post_decode", S_DECODE, 1'b0, 7'h13, 1'b1, 1'b0, 1'b0);
        cyc("post_exec", S_EXEC, 1'b0, 7'h13, 1'b1, 1'b0, 1'b0);
        cyc("post_wb", S_WB, 1'b0, 7'h13, 1'b1, 1'b0, 1'b0);
        exp_instret++;

        // Reset asserted in the middle of a MEM wait cycle.
        cyc("mr_fetch", S_FETCH, 1'b1, 7'h00, 1'b1, 1'b0, 1'b0);
        cyc("mr_decode", S_DECODE, 1'b0, 7'h03, 1'b1, 1'b0, 1'b0);
        cyc("mr_exec", S_EXEC, 1'b0, 7'h03, 1'b1, 1'b0, 1'b0);
        cyc("mr_mem", S_MEM, 1'b0, 7'h03, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        bus.mem_ready = 1'b0;
        #2 nreset = 1'b0;
        #1;
        exp_instret = 0;
        compare("mid_mem_reset", {S_FETCH, 8'b1000_0000, 2'b00, 32'd0});
        @(posedge clock);
        #1 nreset = 1'b1;
        $display("mid-MEM reset checked");

        // Fetch timeout: 16 stalled FETCH cycles then TRAP cause 10.
        for (int i = 0; i < 16; i++) begin
            cyc("fetch_wait", S_FETCH, 1'b0, 7'h00, 1'b1, 1'b1, 1'b0);
        end
        exp_cause = 2'b10;
        cyc("fetch_timeout_trap", S_TRAP, 1'b1, 7'h00, 1'b1, 1'b1, 1'b0);
        $display("fetch timeout checked");
        do_reset("reset_after_fetch_timeout");

        // Illegal opcode: sticky TRAP, strobes quiet despite activity.
        cyc("ill_fetch", S_FETCH, 1'b1, 7'h00, 1'b1, 1'b1, 1'b0);
        cyc("ill_decode", S_DECODE, 1'b0, 7'h7F, 1'b1, 1'b1, 1'b0);
        exp_cause = 2'b01;
        for (int i = 0; i < 20; i++) begin
            cyc("ill_trap", S_TRAP, i[0], 7'h03, 1'b1, 1'b1, i[1]);
        end
        $display("illegal opcode checked");
        do_reset("reset_after_illegal");

        // Data timeout: load whose MEM never completes.
        cyc("dto_fetch", S_FETCH, 1'b1, 7'h00, 1'b1, 1'b0, 1'b0);
        cyc("dto_decode", S_DECODE, 1'b0, 7'h03, 1'b1, 1'b0, 1'b0);
        cyc("dto_exec", S_EXEC, 1'b0, 7'h03, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cyc("dto_mem", S_MEM, 1'b0, 7'h03, 1'b1, 1'b0, 1'b0);
        end
        exp_cause = 2'b11;
        cyc("data_timeout_trap", S_TRAP, 1'b0, 7'h03, 1'b1, 1'b0, 1'b0);
        $display("data timeout checked");
        do_reset("reset_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
